// File: rtl/pipeline_hazard_control_pkg.sv
// Shared types for the pipeline hazard controller.
// Register-field width and halt/dmem-wait state encoding.
package pipeline_hazard_control_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } hazard_state_t;

endpackage

// File: rtl/pipeline_hazard_control_sat_counter.sv
// Saturating up-counter with synchronous clear and enable.
// Clear dominates enable; the count holds at all-ones.
module hazard_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge CLK) begin
        if (clr)
            cnt <= '0;
        else if (en && (cnt != '1))
            cnt <= cnt + CNT_W'(1);
    end

endmodule

// File: rtl/pipeline_hazard_control.sv
// Central stall/flush controller for the 5-stage pipeline.
// Drives per-latch pause/nop, PC enable, halt FSM and perf counters.
module pipeline_hazard_control
    import pipeline_hazard_control_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dmemren,
    input  logic             mem_dmemwen,
    input  logic             mem_redirect,
    input  logic             ex_memread,
    input  regbits_t         ex_rd,
    input  regbits_t         id_rs,
    input  regbits_t         id_rt,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             fd_pause,
    output logic             de_pause,
    output logic             em_pause,
    output logic             mw_pause,
    output logic             fd_nop,
    output logic             de_nop,
    output logic             em_nop,
    output logic             mw_nop,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hazard_state_t state, next_state;

    logic dmem_pend, load_use;
    logic r_halt, r_dmem, r_redir, r_lu, r_miss;
    logic cnt_en;

    assign dmem_pend = (mem_dmemren | mem_dmemwen) & ~dhit;
    assign load_use  = ex_memread & (ex_rd != '0) &
                       ((ex_rd == id_rs) | (ex_rd == id_rt));

    // One-hot winning rule, highest priority first.
    assign r_halt  = (state == HALT) | wb_halt;
    assign r_dmem  = ~r_halt & dmem_pend;
    assign r_redir = ~r_halt & ~dmem_pend & mem_redirect;
    assign r_lu    = ~r_halt & ~dmem_pend & ~mem_redirect & load_use;
    assign r_miss  = ~r_halt & ~dmem_pend & ~mem_redirect & ~load_use
                     & ~ihit;

    always_comb begin
        pc_en    = 1'b1;
        fd_pause = 1'b0;
        de_pause = 1'b0;
        em_pause = 1'b0;
        mw_pause = 1'b0;
        fd_nop   = 1'b0;
        de_nop   = 1'b0;
        em_nop   = 1'b0;
        mw_nop   = 1'b0;
        if (RST) begin
            pc_en  = 1'b0;
            fd_nop = 1'b1;
            de_nop = 1'b1;
            em_nop = 1'b1;
            mw_nop = 1'b1;
        end else begin
            unique case (1'b1)
                r_halt: begin
                    pc_en    = 1'b0;
                    fd_pause = 1'b1;
                    de_pause = 1'b1;
                    em_pause = 1'b1;
                    mw_pause = 1'b1;
                end
                r_dmem: begin
                    pc_en    = 1'b0;
                    fd_pause = 1'b1;
                    de_pause = 1'b1;
                    em_pause = 1'b1;
                    mw_nop   = 1'b1;
                end
                r_redir: begin
                    fd_nop = 1'b1;
                    de_nop = 1'b1;
                    em_nop = 1'b1;
                end
                r_lu: begin
                    pc_en    = 1'b0;
                    fd_pause = 1'b1;
                    de_nop   = 1'b1;
                end
                r_miss: begin
                    pc_en  = 1'b0;
                    fd_nop = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        if (wb_halt) begin
            next_state = HALT;
        end else begin
            unique case (state)
                RUN:     if (dmem_pend) next_state = DWAIT;
                DWAIT:   if (dhit) next_state = RUN;
                HALT:    next_state = HALT;
                default: next_state = RUN;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST)
            state <= RUN;
        else
            state <= next_state;
    end

    assign halted = (state == HALT);
    assign cnt_en = ~RST & (state != HALT);

    hazard_sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .CLK (CLK),
        .clr (RST),
        .en  (cnt_en),
        .cnt (cycle_cnt)
    );

    hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .CLK (CLK),
        .clr (RST),
        .en  (cnt_en & ~pc_en),
        .cnt (stall_cnt)
    );

    hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .CLK (CLK),
        .clr (RST),
        .en  (cnt_en & r_redir),
        .cnt (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_control.sv
// Directed self-checking bench for pipeline_hazard_control.
// A second 4-bit-counter instance shares the stimulus for saturation.
module tb_pipeline_hazard_control;
    import pipeline_hazard_control_pkg::*;

    logic CLK = 1'b0;
    logic RST, ihit, dhit, mem_dmemren, mem_dmemwen, mem_redirect;
    logic ex_memread, wb_halt;
    regbits_t ex_rd, id_rs, id_rt;

    logic pc_en, fd_pause, de_pause, em_pause, mw_pause;
    logic fd_nop, de_nop, em_nop, mw_nop, halted;
    logic [31:0] cycle_cnt, stall_cnt, flush_cnt;

    logic pc_en4, fdp4, dep4, emp4, mwp4, fdn4, den4, emn4, mwn4, halted4;
    logic [3:0] cyc4, stl4, fls4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    pipeline_hazard_control #(.CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .mem_dmemren(mem_dmemren), .mem_dmemwen(mem_dmemwen),
        .mem_redirect(mem_redirect), .ex_memread(ex_memread),
        .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt),
        .wb_halt(wb_halt), .pc_en(pc_en),
        .fd_pause(fd_pause), .de_pause(de_pause),
        .em_pause(em_pause), .mw_pause(mw_pause),
        .fd_nop(fd_nop), .de_nop(de_nop),
        .em_nop(em_nop), .mw_nop(mw_nop),
        .halted(halted), .cycle_cnt(cycle_cnt),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_hazard_control #(.CNT_W(4)) dut4 (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .mem_dmemren(mem_dmemren), .mem_dmemwen(mem_dmemwen),
        .mem_redirect(mem_redirect), .ex_memread(ex_memread),
        .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt),
        .wb_halt(wb_halt), .pc_en(pc_en4),
        .fd_pause(fdp4), .de_pause(dep4),
        .em_pause(emp4), .mw_pause(mwp4),
        .fd_nop(fdn4), .de_nop(den4),
        .em_nop(emn4), .mw_nop(mwn4),
        .halted(halted4), .cycle_cnt(cyc4),
        .stall_cnt(stl4), .flush_cnt(fls4)
    );

    wire [3:0] pause_v = {fd_pause, de_pause, em_pause, mw_pause};
    wire [3:0] nop_v   = {fd_nop, de_nop, em_nop, mw_nop};

    task automatic check_eq(input string tag,
                            input logic [31:0] obs,
                            input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        ihit = 1'b1; dhit = 1'b0;
        mem_dmemren = 1'b0; mem_dmemwen = 1'b0;
        mem_redirect = 1'b0; ex_memread = 1'b0;
        ex_rd = '0; id_rs = '0; id_rt = '0;
        wb_halt = 1'b0;
    endtask

    task automatic ctl(input string tag, input logic pc,
                       input logic [3:0] p, input logic [3:0] n);
        #1;
        check_eq({tag, "_pc_en"}, 32'(pc), 32'(pc_en));
        check_eq({tag, "_pause"}, 32'(pause_v), 32'(p));
        check_eq({tag, "_nop"}, 32'(nop_v), 32'(n));
    endtask

    task automatic cnts(input string tag, input int c,
                        input int s, input int f);
        check_eq({tag, "_cycle"}, cycle_cnt, c);
        check_eq({tag, "_stall"}, stall_cnt, s);
        check_eq({tag, "_flush"}, flush_cnt, f);
    endtask

    initial begin
        RST = 1'b1;
        idle();
        tick();
        tick();
        ctl("rst", 1'b0, 4'b0000, 4'b1111);
        RST = 1'b0;
        #1;
        cnts("rst_rel", 0, 0, 0);
        check_eq("rst_halted", 32'(halted), 0);
        check_eq("rst_state", 32'(dut.state), 32'(RUN));

        ex_memread = 1'b1; ex_rd = 5'd5; id_rt = 5'd5;
        ctl("lu", 1'b0, 4'b1000, 4'b0100);
        tick();
        cnts("lu", 1, 1, 0);

        ex_rd = 5'd0; id_rt = 5'd0;
        ctl("lu_r0", 1'b1, 4'b0000, 4'b0000);
        tick();
        cnts("lu_r0", 2, 1, 0);

        ex_rd = 5'd9; id_rs = 5'd9; ihit = 1'b0;
        ctl("lu_miss", 1'b0, 4'b1000, 4'b0100);
        tick();
        cnts("lu_miss", 3, 2, 0);

        idle(); ihit = 1'b0;
        ctl("miss", 1'b0, 4'b0000, 4'b1000);
        tick();
        cnts("miss", 4, 3, 0);

        idle(); mem_dmemren = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ctl("dwait", 1'b0, 4'b1110, 4'b0001);
            tick();
            check_eq("dwait_state", 32'(dut.state), 32'(DWAIT));
        end
        cnts("dwait", 7, 6, 0);
        dhit = 1'b1;
        ctl("dhit", 1'b1, 4'b0000, 4'b0000);
        tick();
        check_eq("dhit_state", 32'(dut.state), 32'(RUN));
        cnts("dhit", 8, 6, 0);

        idle(); mem_redirect = 1'b1; ihit = 1'b0;
        ctl("redir", 1'b1, 4'b0000, 4'b1110);
        tick();
        cnts("redir", 9, 6, 1);

        idle(); mem_redirect = 1'b1; mem_dmemwen = 1'b1;
        ctl("redir_dm", 1'b0, 4'b1110, 4'b0001);
        tick();
        cnts("redir_dm", 10, 7, 1);
        dhit = 1'b1;
        ctl("redir_dhit", 1'b1, 4'b0000, 4'b1110);
        tick();
        cnts("redir_dhit", 11, 7, 2);

        idle(); wb_halt = 1'b1; mem_redirect = 1'b1;
        ctl("halt", 1'b0, 4'b1111, 4'b0000);
        check_eq("halt_pre", 32'(halted), 0);
        tick();
        check_eq("halt_post", 32'(halted), 1);
        cnts("halt", 12, 8, 2);
        wb_halt = 1'b0; ihit = 1'b0;
        ctl("halted_ctl", 1'b0, 4'b1111, 4'b0000);
        tick(); tick(); tick();
        cnts("frozen", 12, 8, 2);
        check_eq("halt_sticky", 32'(halted), 1);

        RST = 1'b1;
        ctl("rst_halt", 1'b0, 4'b0000, 4'b1111);
        tick();
        RST = 1'b0;
        idle();
        #1;
        cnts("rst_halt", 0, 0, 0);
        check_eq("rst_halt_st", 32'(dut.state), 32'(RUN));
        check_eq("rst_halted2", 32'(halted), 0);

        mem_dmemren = 1'b1;
        tick();
        check_eq("mid_dwait", 32'(dut.state), 32'(DWAIT));
        RST = 1'b1;
        tick();
        check_eq("rst_dwait", 32'(dut.state), 32'(RUN));
        RST = 1'b0;
        idle(); ihit = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        cnts("sat32", 20, 20, 0);
        check_eq("sat_cycle", 32'(cyc4), 15);
        check_eq("sat_stall", 32'(stl4), 15);
        check_eq("sat_flush", 32'(fls4), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
